// File: rtl/cin_packer.sv
// cin_packer: gathers two consecutive half-width feature beats into one full-width beat,
// flushing an odd burst tail with a zero upper half.
`ifndef PICTURE_NUM
`define PICTURE_NUM 1
`endif
`ifndef Channel_Out_Num
`define Channel_Out_Num 8
`endif
module cin_packer #(
    parameter int PICTURE_NUM          = `PICTURE_NUM,
    parameter int Half_Channel_Out_Num = `Channel_Out_Num >> 1,
    parameter int HW                   = PICTURE_NUM * Half_Channel_Out_Num * 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [HW-1:0]   S_Feature,
    input  logic            S_Valid,
    input  logic            S_Last,
    output logic            S_Ready,
    output logic [2*HW-1:0] M_Feature,
    output logic            M_Valid,
    output logic            M_Last,
    input  logic            M_Ready
);
    typedef enum logic [1:0] {WAIT_LO, HAVE_LO, FLUSH} state_t;
    state_t            state_q, state_d;
    logic [HW-1:0]     lo_q;
    logic [2*HW-1:0]   feat_q, pack_d;
    logic              valid_q, last_q, last_d, out_free, accept, load_d;
    assign M_Feature = feat_q;
    assign M_Valid   = valid_q;
    assign M_Last    = last_q;
    always_comb begin
        out_free = ~valid_q | M_Ready;
        S_Ready  = (state_q == WAIT_LO) | ((state_q == HAVE_LO) & out_free);
        accept   = S_Valid & S_Ready;
        load_d   = ((state_q == HAVE_LO) & accept) | ((state_q == FLUSH) & out_free);
        pack_d   = (state_q == FLUSH) ? {{HW{1'b0}}, lo_q} : {S_Feature, lo_q};
        last_d   = (state_q == FLUSH) | S_Last;
        state_d  = (state_q == WAIT_LO) ? (accept ? (S_Last ? FLUSH : HAVE_LO) : WAIT_LO)
                 : load_d ? WAIT_LO : state_q;
    end
    // A new load takes priority over a take so packed beats can go out back to back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WAIT_LO;
            lo_q    <= '0;
            feat_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == WAIT_LO) && accept) lo_q <= S_Feature;
            if (load_d) begin
                feat_q  <= pack_d;
                valid_q <= 1'b1;
                last_q  <= last_d;
            end else if (valid_q && M_Ready) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cin_packer.sv
// tb_cin_packer: scoreboard bench for the half-to-full width channel packer.
module tb_cin_packer;
    localparam int HW = 32;
    logic            clk, rst;
    logic [HW-1:0]   S_Feature;
    logic            S_Valid, S_Last, S_Ready;
    logic [2*HW-1:0] M_Feature;
    logic            M_Valid, M_Last, M_Ready;
    int errors = 0;
    int checks = 0;
    logic [2*HW:0] sb_q[$];
    logic [2*HW:0] exp_w;
    logic          mon_en = 0;
    logic          m_have = 0;
    logic [HW-1:0] m_lo;
    logic          stall_prev = 0;
    logic [2*HW-1:0] prev_f;
    logic          prev_l;
    cin_packer #(.PICTURE_NUM(1), .Half_Channel_Out_Num(4)) dut (
        .clk(clk), .rst(rst), .S_Feature(S_Feature), .S_Valid(S_Valid), .S_Last(S_Last),
        .S_Ready(S_Ready), .M_Feature(M_Feature), .M_Valid(M_Valid), .M_Last(M_Last),
        .M_Ready(M_Ready)
    );
    initial clk = 0;
    always #5 clk = ~clk;
    // Reference model: pairs accepted beats, pads odd tails, checks every taken beat in order.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (stall_prev) begin
                checks++;
                if (M_Valid !== 1'b1 || M_Feature !== prev_f || M_Last !== prev_l) begin
                    errors++;
                    $display("FAIL stall_stable: got v=%b f=%h l=%b, required v=1 f=%h l=%b",
                             M_Valid, M_Feature, M_Last, prev_f, prev_l);
                end
            end
            stall_prev = M_Valid && !M_Ready;
            prev_f = M_Feature;
            prev_l = M_Last;
            if (M_Valid && M_Ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got f=%h l=%b, required no output", M_Feature, M_Last);
                end else begin
                    exp_w = sb_q.pop_front();
                    if ({M_Last, M_Feature} !== exp_w) begin
                        errors++;
                        $display("FAIL sb_data: got l=%b f=%h, required l=%b f=%h",
                                 M_Last, M_Feature, exp_w[2*HW], exp_w[2*HW-1:0]);
                    end
                end
            end
            if (S_Valid && S_Ready) begin
                if (!m_have) begin
                    m_lo = S_Feature;
                    if (S_Last) sb_q.push_back({1'b1, {HW{1'b0}}, S_Feature});
                    else m_have = 1;
                end else begin
                    sb_q.push_back({S_Last, S_Feature, m_lo});
                    m_have = 0;
                end
            end
        end
    end
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic drain();
        int n;
        S_Valid = 0;
        M_Ready = 1;
        n = 0;
        while ((sb_q.size() != 0 || M_Valid) && n < 200) begin
            cyc();
            n++;
        end
        cyc();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending outputs, required 0", sb_q.size());
        end
    endtask
    task automatic test_reset();
        int n;
        rst = 1; S_Valid = 0; S_Last = 0; S_Feature = '0; M_Ready = 0;
        #12;
        checks++;
        if (M_Valid !== 0 || M_Feature !== '0 || M_Last !== 0) begin
            errors++;
            $display("FAIL reset_state: got v=%b f=%h l=%b, required 0/0/0", M_Valid, M_Feature, M_Last);
        end
        rst = 0;
        cyc();
        S_Valid = 1; S_Feature = 32'h1; cyc();
        S_Feature = 32'h2; cyc();
        S_Feature = 32'h11111111; cyc();
        S_Valid = 0;
        checks++;
        if (M_Valid !== 1 || M_Feature !== 64'h00000002_00000001) begin
            errors++;
            $display("FAIL pre_reset_out: got v=%b f=%h, required v=1 f=0000000200000001", M_Valid, M_Feature);
        end
        #2 rst = 1;
        #1;
        checks++;
        if (M_Valid !== 0 || M_Feature !== '0) begin
            errors++;
            $display("FAIL async_reset: got v=%b f=%h, required v=0 f=0", M_Valid, M_Feature);
        end
        #3 rst = 0;
        m_have = 0; sb_q.delete(); stall_prev = 0; mon_en = 1;
        M_Ready = 1;
        cyc();
        S_Valid = 1; S_Feature = 32'hA; cyc();
        S_Feature = 32'hB; cyc();
        S_Valid = 0;
        n = 0;
        while (!M_Valid && n < 10) begin
            cyc();
            n++;
        end
        checks++;
        if (M_Valid !== 1 || M_Feature !== 64'h0000000B_0000000A) begin
            errors++;
            $display("FAIL reset_resume: got v=%b f=%h, required v=1 f=0000000B0000000A", M_Valid, M_Feature);
        end
        drain();
    endtask
    task automatic test_stream();
        for (int i = 1; i <= 9; i++) begin
            S_Valid = (i <= 8); S_Feature = i; S_Last = 0;
            @(negedge clk);
            checks++;
            if (i <= 8 && S_Ready !== 1) begin
                errors++;
                $display("FAIL stream_ready: beat %0d got %b, required 1", i, S_Ready);
            end
            checks++;
            if (M_Valid !== (i > 2 && i % 2 == 1)) begin
                errors++;
                $display("FAIL stream_valid: cycle %0d got %b, required %b", i, M_Valid, (i > 2 && i % 2 == 1));
            end
            cyc();
        end
        drain();
    endtask
    task automatic test_backpressure();
        M_Ready = 0; S_Last = 0;
        S_Valid = 1; S_Feature = 32'h1; cyc();
        S_Feature = 32'h2; cyc();
        S_Feature = 32'h3;
        @(negedge clk);
        checks++;
        if (M_Valid !== 1 || M_Feature !== 64'h00000002_00000001 || S_Ready !== 1) begin
            errors++;
            $display("FAIL bp_first: got v=%b f=%h r=%b, required v=1 f=0000000200000001 r=1",
                     M_Valid, M_Feature, S_Ready);
        end
        cyc();
        S_Feature = 32'h4;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (S_Ready !== 0 || M_Feature !== 64'h00000002_00000001) begin
                errors++;
                $display("FAIL bp_hold: got r=%b f=%h, required r=0 f=0000000200000001", S_Ready, M_Feature);
            end
            cyc();
        end
        M_Ready = 1;
        @(negedge clk);
        checks++;
        if (S_Ready !== 1) begin
            errors++;
            $display("FAIL bp_release: got r=%b, required 1", S_Ready);
        end
        cyc();
        M_Ready = 0; S_Valid = 0;
        @(negedge clk);
        checks++;
        if (M_Valid !== 1 || M_Feature !== 64'h00000004_00000003) begin
            errors++;
            $display("FAIL bp_second: got v=%b f=%h, required v=1 f=0000000400000003", M_Valid, M_Feature);
        end
        cyc();
        drain();
    endtask
    task automatic test_odd_burst();
        logic [HW-1:0] d[3] = '{32'h5, 32'h6, 32'h7};
        M_Ready = 1;
        for (int i = 0; i < 5; i++) begin
            S_Valid = (i < 3); S_Feature = (i < 3) ? d[i] : '0; S_Last = (i == 2);
            @(negedge clk);
            checks++;
            if (S_Ready !== (i != 3)) begin
                errors++;
                $display("FAIL odd_ready: cycle %0d got %b, required %b", i, S_Ready, (i != 3));
            end
            if (i == 2) begin
                checks++;
                if (M_Valid !== 1 || M_Feature !== 64'h00000006_00000005 || M_Last !== 0) begin
                    errors++;
                    $display("FAIL odd_pair: got v=%b f=%h l=%b, required v=1 f=0000000600000005 l=0",
                             M_Valid, M_Feature, M_Last);
                end
            end
            if (i == 4) begin
                checks++;
                if (M_Valid !== 1 || M_Feature !== 64'h00000000_00000007 || M_Last !== 1) begin
                    errors++;
                    $display("FAIL odd_flush: got v=%b f=%h l=%b, required v=1 f=0000000000000007 l=1",
                             M_Valid, M_Feature, M_Last);
                end
            end
            cyc();
        end
        S_Last = 0;
        drain();
    endtask
    task automatic test_even_burst();
        M_Ready = 1;
        S_Valid = 1; S_Last = 0; S_Feature = 32'hC; cyc();
        S_Last = 1; S_Feature = 32'hD; cyc();
        S_Last = 0; S_Feature = 32'hE;
        @(negedge clk);
        checks++;
        if (M_Valid !== 1 || M_Last !== 1 || M_Feature !== 64'h0000000D_0000000C || S_Ready !== 1) begin
            errors++;
            $display("FAIL even_end: got v=%b l=%b f=%h r=%b, required v=1 l=1 f=0000000D0000000C r=1",
                     M_Valid, M_Last, M_Feature, S_Ready);
        end
        cyc();
        S_Feature = 32'hF;
        @(negedge clk);
        checks++;
        if (M_Valid !== 0) begin
            errors++;
            $display("FAIL even_single: got v=%b, required 0", M_Valid);
        end
        cyc();
        S_Valid = 0;
        @(negedge clk);
        checks++;
        if (M_Valid !== 1 || M_Last !== 0 || M_Feature !== 64'h0000000F_0000000E) begin
            errors++;
            $display("FAIL even_next: got v=%b l=%b f=%h, required v=1 l=0 f=0000000F0000000E",
                     M_Valid, M_Last, M_Feature);
        end
        cyc();
        drain();
    endtask
    task automatic test_random();
        int sent, n;
        logic r0, r1;
        sent = 0; n = 0;
        while (sent < 10000 && n < 70000) begin
            S_Valid = $urandom_range(0, 1);
            M_Ready = $urandom_range(0, 1);
            S_Feature = $urandom;
            S_Last = (sent == 9999) ? 1'b1 : ($urandom_range(0, 3) == 0);
            #1 r0 = S_Ready;
            S_Valid = ~S_Valid;
            #1 r1 = S_Ready;
            S_Valid = ~S_Valid;
            checks++;
            if (r0 !== r1) begin
                errors++;
                $display("FAIL ready_indep: got %b with S_Valid flipped, required %b", r1, r0);
            end
            @(negedge clk);
            if (S_Valid && S_Ready) sent++;
            cyc();
            n++;
        end
        checks++;
        if (sent < 10000) begin
            errors++;
            $display("FAIL random_timeout: got %0d beats accepted, required 10000", sent);
        end
        S_Last = 0;
        drain();
    endtask
    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_odd_burst();
        test_even_burst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
